// File: rtl/consumer_pkg.sv
// consumer_pkg: shared lane state encoding and default widths for the
// consumer FSM (sink end of the two-pipeline datapath).
package consumer_pkg;

  localparam int DATA_W_DEF       = 32;
  localparam int CNT_W_DEF        = 8;
  localparam int STALL_PERIOD_DEF = 4;

  // Per-lane epoch state: waiting for a first beat, collecting beats, or
  // publishing the report of the epoch that just closed.
  typedef enum logic [1:0] {
    LANE_IDLE   = 2'd0,
    LANE_ACTIVE = 2'd1,
    LANE_REPORT = 2'd2
  } lane_state_e;

endpackage : consumer_pkg

// File: rtl/consumer_lane.sv
// consumer_lane: one sink lane -- epoch FSM, saturating beat counter,
// wrapping checksum accumulator and report registers.
// Optional macro SEQ_CHECK_EN adds the sticky "beat == previous + 1" check;
// without it seq_err is tied low and no last-beat storage exists.
module consumer_lane
  import consumer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  input  logic              flush,
  output logic              ready,
  output logic              report_valid,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] sum,
  output logic              seq_err
);

  lane_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_next;
  logic [DATA_W-1:0] acc_q, acc_next;
  logic              beat;

  // Ready is held low during reset, on stall cycles and while reporting.
  assign ready        = reset && !stall && (state_q != LANE_REPORT);
  assign beat         = valid && ready;
  assign report_valid = (state_q == LANE_REPORT);

  // Epoch totals including this cycle's beat (counter saturates).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_next = cnt_q;
    acc_next = acc_q;
    if (beat) begin
      if (cnt_q != '1) cnt_next = cnt_q + CNT_W'(1);
      acc_next = acc_q + data;
    end
  end

  // Next-state logic; a flush always wins and closes the epoch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LANE_IDLE, LANE_ACTIVE: begin
        if (flush)     state_d = LANE_REPORT;
        else if (beat) state_d = LANE_ACTIVE;
      end
      LANE_REPORT: state_d = flush ? LANE_REPORT : LANE_IDLE;
      default:     state_d = LANE_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!reset) state_q <= LANE_IDLE;
    else        state_q <= state_d;
  end

  // Running totals; a flush publishes them (same-cycle beat included) and restarts the epoch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      acc_q <= '0;
      count <= '0;
      sum   <= '0;
    end else if (flush) begin
      count <= cnt_next;
      sum   <= acc_next;
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_next;
      acc_q <= acc_next;
    end
  end

`ifdef SEQ_CHECK_EN
  logic [DATA_W-1:0] last_q;
  logic              last_vld_q;
  logic              seq_err_q;

  // Sticky sequence check; the first beat of an epoch only seeds last_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      if (beat) begin
        if (last_vld_q && (data != last_q + DATA_W'(1))) seq_err_q <= 1'b1;
        last_q <= data;
      end
      last_vld_q <= flush ? 1'b0 : (last_vld_q || beat);
    end
  end

  assign seq_err = seq_err_q;
`else
  assign seq_err = 1'b0;
`endif

endmodule : consumer_lane

// File: rtl/consumer_fsm.sv
// consumer_fsm: sink of the two-pipeline datapath. Holds the shared stall
// counter (ready drops one cycle in every STALL_PERIOD, 0 = never) and maps
// the two independent consumer_lane instances onto the ports.
// Optional macro SEQ_CHECK_EN enables the per-lane sticky sequence check.
module consumer_fsm
  import consumer_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int STALL_PERIOD = STALL_PERIOD_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pipeline1_outputs,
  input  logic [DATA_W-1:0] pipeline2_outputs,
  input  logic [1:0]        out_valid,
  output logic [1:0]        out_ready,
  input  logic              flush_1,
  input  logic              flush_2,
  output logic [1:0]        report_valid,
  output logic [CNT_W-1:0]  lane0_count,
  output logic [CNT_W-1:0]  lane1_count,
  output logic [DATA_W-1:0] lane0_sum,
  output logic [DATA_W-1:0] lane1_sum,
  output logic [1:0]        seq_err
);

  localparam int SC_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [SC_W-1:0] STALL_LAST = SC_W'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);

  logic [SC_W-1:0] stall_cnt;
  logic            stall;

  assign stall = (STALL_PERIOD != 0) && (stall_cnt == STALL_LAST);

  // Free-running stall phase counter, parked at 0 when stalling is disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            stall_cnt <= '0;
    else if ((STALL_PERIOD == 0) || stall) stall_cnt <= '0;
    else                                   stall_cnt <= stall_cnt + SC_W'(1);
  end

  consumer_lane #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_lane0 (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .valid        (out_valid[0]),
    .data         (pipeline1_outputs),
    .flush        (flush_1),
    .ready        (out_ready[0]),
    .report_valid (report_valid[0]),
    .count        (lane0_count),
    .sum          (lane0_sum),
    .seq_err      (seq_err[0])
  );

  consumer_lane #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_lane1 (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .valid        (out_valid[1]),
    .data         (pipeline2_outputs),
    .flush        (flush_2),
    .ready        (out_ready[1]),
    .report_valid (report_valid[1]),
    .count        (lane1_count),
    .sum          (lane1_sum),
    .seq_err      (seq_err[1])
  );

endmodule : consumer_fsm

// File: tb/tb_consumer_fsm.sv
// tb_consumer_fsm: two consumer_fsm instances (STALL_PERIOD 0 and 4) share
// one stimulus stream; a queue-based epoch model predicts every output.
module tb_consumer_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] p1, p2;
  logic [1:0]  valid;
  logic        f1, f2;

  logic [1:0]  rdy[2];
  logic [1:0]  rv[2];
  logic [1:0]  serr[2];
  logic [7:0]  c0[2], c1[2];
  logic [31:0] s0[2], s1[2];
  logic [1:0]  rdy_seen[2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  consumer_fsm #(.DATA_W(32), .CNT_W(8), .STALL_PERIOD(0)) dut_p0 (
    .clk(clk), .reset(reset), .pipeline1_outputs(p1), .pipeline2_outputs(p2),
    .out_valid(valid), .out_ready(rdy[0]), .flush_1(f1), .flush_2(f2),
    .report_valid(rv[0]), .lane0_count(c0[0]), .lane1_count(c1[0]),
    .lane0_sum(s0[0]), .lane1_sum(s1[0]), .seq_err(serr[0]));

  consumer_fsm #(.DATA_W(32), .CNT_W(8), .STALL_PERIOD(4)) dut_p4 (
    .clk(clk), .reset(reset), .pipeline1_outputs(p1), .pipeline2_outputs(p2),
    .out_valid(valid), .out_ready(rdy[1]), .flush_1(f1), .flush_2(f2),
    .report_valid(rv[1]), .lane0_count(c0[1]), .lane1_count(c1[1]),
    .lane0_sum(s0[1]), .lane1_sum(s1[1]), .seq_err(serr[1]));

`ifdef SEQ_CHECK_EN
  localparam bit SEQ_ON = 1'b1;
`else
  localparam bit SEQ_ON = 1'b0;
`endif

  // Reference model: beats of the open epoch kept as a queue per DUT/lane.
  int          edges;
  bit          rep[2][2];
  logic [31:0] ep_q[2][2][$];
  logic [7:0]  pub_cnt[2][2];
  logic [31:0] pub_sum[2][2];
  bit          m_serr[2][2];

  function automatic int period(int d);
    return (d == 0) ? 0 : 4;
  endfunction

  function automatic bit exp_ready(int d, int l);
    bit st;
    st = (period(d) != 0) && ((edges % period(d)) == period(d) - 1);
    return reset && !st && !rep[d][l];
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    edges = 0;
    for (int d = 0; d < 2; d++)
      for (int l = 0; l < 2; l++) begin
        rep[d][l] = 1'b0;
        ep_q[d][l].delete();
        pub_cnt[d][l] = '0;
        pub_sum[d][l] = '0;
        m_serr[d][l] = 1'b0;
      end
  endtask

  task automatic model_clock();
    for (int d = 0; d < 2; d++)
      for (int l = 0; l < 2; l++) begin
        logic [31:0] dat;
        logic [31:0] tot;
        bit          fl;
        dat = (l == 0) ? p1 : p2;
        fl  = (l == 0) ? f1 : f2;
        if (valid[l] && exp_ready(d, l)) begin
          if (SEQ_ON && ep_q[d][l].size() > 0 && dat != ep_q[d][l][$] + 32'd1)
            m_serr[d][l] = 1'b1;
          ep_q[d][l].push_back(dat);
        end
        if (fl) begin
          tot = '0;
          foreach (ep_q[d][l][i]) tot += ep_q[d][l][i];
          pub_cnt[d][l] = (ep_q[d][l].size() > 255) ? 8'd255 : 8'(ep_q[d][l].size());
          pub_sum[d][l] = tot;
          ep_q[d][l].delete();
        end
        rep[d][l] = fl;
      end
    edges++;
  endtask

  task automatic check_outputs();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_ready", d), 32'(rdy[d]), 32'({exp_ready(d, 1), exp_ready(d, 0)}));
      check($sformatf("d%0d_report_valid", d), 32'(rv[d]), 32'({rep[d][1], rep[d][0]}));
      check($sformatf("d%0d_lane0_count", d), 32'(c0[d]), 32'(pub_cnt[d][0]));
      check($sformatf("d%0d_lane1_count", d), 32'(c1[d]), 32'(pub_cnt[d][1]));
      check($sformatf("d%0d_lane0_sum", d), s0[d], pub_sum[d][0]);
      check($sformatf("d%0d_lane1_sum", d), s1[d], pub_sum[d][1]);
      check($sformatf("d%0d_seq_err", d), 32'(serr[d]), 32'({m_serr[d][1], m_serr[d][0]}));
      rdy_seen[d] = rdy[d];
    end
  endtask

  // One clock cycle: inputs are already applied; settle, compare, advance.
  task automatic step();
    #1;
    check_outputs();
    if (reset) model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [1:0] v, logic [31:0] d0, logic [31:0] d1, logic fl1, logic fl2);
    valid = v; p1 = d0; p2 = d1; f1 = fl1; f2 = fl2;
    step();
  endtask

  // Asynchronous reset in the middle of a cycle, checked before any edge.
  task automatic mid_cycle_reset(int hold);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    for (int i = 0; i < hold; i++) drive(2'b11, $urandom, $urandom, 1'b1, 1'b1);
    reset = 1'b1;
  endtask

  initial begin
    int          k;
    int          n_rdy;
    logic [31:0] seq0, seq1;

    reset = 1'b0; valid = '0; p1 = '0; p2 = '0; f1 = 1'b0; f2 = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    // Reset state, with flushes and valid driven to show they are ignored.
    for (int i = 0; i < 3; i++) drive(2'b11, 32'h55, 32'h66, 1'b1, 1'b1);
    reset = 1'b1;

    // Lane 0: beats 0..8 then flush -> report 9 / 36 on the unstalled DUT.
    for (int i = 0; i < 9; i++) drive(2'b01, 32'(i), 32'd0, 1'b0, 1'b0);
    drive(2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
    check("A_report_valid", 32'(rv[0]), 32'h1);
    check("A_lane0_count", 32'(c0[0]), 32'd9);
    check("A_lane0_sum", s0[0], 32'd36);
    check("A_seq_err", 32'(serr[0]), 32'd0);

    // Lane 1: beats 2,3 with flush on the beat of 3.
    drive(2'b10, 32'd0, 32'd2, 1'b0, 1'b0);
    drive(2'b10, 32'd0, 32'd3, 1'b0, 1'b1);
    check("B_report_valid", 32'(rv[0]), 32'h2);
    check("B_lane1_count", 32'(c1[0]), 32'd2);
    check("B_lane1_sum", s1[0], 32'd5);
    check("B_lane0_count_held", 32'(c0[0]), 32'd9);
    check("B_lane0_sum_held", s0[0], 32'd36);

    // Stall period 4: valid held 12 cycles, data advances only when accepted.
    drive(2'b00, 32'd0, 32'd0, 1'b1, 1'b1);
    drive(2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
    k = 0; n_rdy = 0;
    for (int i = 0; i < 12; i++) begin
      drive(2'b01, 32'd100 + 32'(k), 32'd0, 1'b0, 1'b0);
      n_rdy += int'(rdy_seen[1][0]);
      k     += int'(rdy_seen[1][0]);
    end
    check("C_ready_cycles", 32'(n_rdy), 32'd9);
    drive(2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
    check("C_report_valid", 32'(rv[1][0]), 32'd1);
    check("C_lane0_count", 32'(c0[1]), 32'd9);
    check("C_lane0_sum", s0[1], 32'd936);

    // Flush in the report cycle -> second report of 0 / 0.
    drive(2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(2'b01, 32'd7, 32'd0, 1'b0, 1'b0);
    drive(2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
    check("D_first_report", 32'(rv[0][0]), 32'd1);
    check("D_first_count", 32'(c0[0]), 32'd1);
    check("D_first_sum", s0[0], 32'd7);
    drive(2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
    check("D_second_report", 32'(rv[0][0]), 32'd1);
    check("D_second_count", 32'(c0[0]), 32'd0);
    check("D_second_sum", s0[0], 32'd0);

    // Sequence 5,6,8 -> sticky error on lane 0 when the check is built in.
    drive(2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(2'b01, 32'd5, 32'd0, 1'b0, 1'b0);
    drive(2'b01, 32'd6, 32'd0, 1'b0, 1'b0);
    check("E_seq_err_before", 32'(serr[0]), 32'd0);
    drive(2'b01, 32'd8, 32'd0, 1'b0, 1'b0);
    check("E_seq_err_set", 32'(serr[0]), 32'(SEQ_ON));
    drive(2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
    drive(2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
    check("E_seq_err_sticky", 32'(serr[0]), 32'(SEQ_ON));

    // Mid-epoch reset after 3 beats: everything clears, no report.
    for (int i = 0; i < 3; i++) drive(2'b01, 32'd20 + 32'(i), 32'd0, 1'b0, 1'b0);
    mid_cycle_reset(1);
    check("F_no_report", 32'(rv[0]), 32'd0);
    check("F_seq_err_cleared", 32'(serr[0]), 32'd0);
    drive(2'b01, 32'd30, 32'd0, 1'b0, 1'b0);
    drive(2'b01, 32'd31, 32'd0, 1'b0, 1'b0);
    drive(2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
    check("F_new_epoch_count", 32'(c0[0]), 32'd2);
    check("F_new_epoch_sum", s0[0], 32'd61);

    // Randomized traffic: mostly in-sequence data, random flushes and resets.
    seq0 = $urandom; seq1 = $urandom;
    for (int i = 0; i < 800; i++) begin
      logic [31:0] d0, d1;
      d0 = ($urandom_range(0, 9) == 0) ? $urandom : seq0 + 32'd1;
      d1 = ($urandom_range(0, 9) == 0) ? $urandom : seq1 + 32'd1;
      seq0 = d0; seq1 = d1;
      if ($urandom_range(0, 199) == 0) begin
        mid_cycle_reset($urandom_range(0, 2));
      end else begin
        drive(2'($urandom), d0, d1,
              $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_consumer_fsm
